// File: rtl/data_path_core_if.sv
// Control/instruction bundle between the external control unit and the
// data_path_core datapath, plus the observed write-back value and PC.
interface data_path_core_if;
  logic        regdest;
  logic        alusrc;
  logic        memtoreg;
  logic        regwrite;
  logic        memread;
  logic        memwrite;
  logic        branch;
  logic        jump;
  logic [15:0] instruct_reg;
  logic [15:0] out;
  logic [15:0] pc_out;

  modport master (
    output regdest, alusrc, memtoreg, regwrite, memread, memwrite,
           branch, jump, instruct_reg,
    input  out, pc_out
  );

  modport slave (
    input  regdest, alusrc, memtoreg, regwrite, memread, memwrite,
           branch, jump, instruct_reg,
    output out, pc_out
  );
endinterface

// File: rtl/data_path_core.sv
// data_path_core: 16-bit single-cycle datapath (PC, 8x16 register file,
// ALU, 256x16 data memory). Instruction and control come from outside.
// Build option: define REGFILE_PRELOAD_EN to make reset load reg[i]=i
// (r0 still 0); otherwise reset clears every register. Memory is always
// cleared by reset.
module data_path_core (
  input  logic             clk,
  input  logic             reset,
  data_path_core_if.slave  bus
);
  localparam int DMEM_DEPTH = 256;
  localparam int NUM_REGS   = 8;

  logic [15:0] r_pc;
  logic [15:0] r_regs [NUM_REGS];
  logic [15:0] r_mem  [DMEM_DEPTH];

  logic [3:0]  w_op;
  logic [2:0]  w_rs;
  logic [2:0]  w_rt;
  logic [2:0]  w_rd;
  logic [2:0]  w_funct;
  logic [5:0]  w_imm6;
  logic [11:0] w_tgt;
  logic [15:0] w_imm_sext;
  logic [15:0] w_rs_data;
  logic [15:0] w_rt_data;
  logic [15:0] w_alu_a;
  logic [15:0] w_alu_b;
  logic [15:0] w_alu_result;
  logic        w_zero;
  logic [15:0] w_mem_rdata;
  logic [15:0] w_wb_data;
  logic [2:0]  w_wr_addr;
  logic [15:0] w_pc_plus1;

  assign w_op       = bus.instruct_reg[15:12];
  assign w_rs       = bus.instruct_reg[11:9];
  assign w_rt       = bus.instruct_reg[8:6];
  assign w_rd       = bus.instruct_reg[5:3];
  assign w_funct    = bus.instruct_reg[2:0];
  assign w_imm6     = bus.instruct_reg[5:0];
  assign w_tgt      = bus.instruct_reg[11:0];
  assign w_imm_sext = {{10{w_imm6[5]}}, w_imm6};
  assign w_pc_plus1 = r_pc + 16'd1;
  assign w_wr_addr  = bus.regdest ? w_rd : w_rt;

  // Register reads are combinational; r0 is hard-wired to zero.
  always_comb begin
    w_rs_data = 16'd0;
    w_rt_data = 16'd0;
    if (w_rs != 3'd0) begin
      w_rs_data = r_regs[w_rs];
    end else begin
      w_rs_data = 16'd0;
    end
    if (w_rt != 3'd0) begin
      w_rt_data = r_regs[w_rt];
    end else begin
      w_rt_data = 16'd0;
    end
  end

  assign w_alu_a = w_rs_data;
  assign w_alu_b = bus.alusrc ? w_imm_sext : w_rt_data;

  // ALU: branch compares by subtraction, non-R-type adds, R-type uses funct.
  always_comb begin
    w_alu_result = 16'd0;
    if (bus.branch) begin
      w_alu_result = w_alu_a - w_alu_b;
    end else if (w_op != 4'd0) begin
      w_alu_result = w_alu_a + w_alu_b;
    end else begin
      case (w_funct)
        3'b000:  w_alu_result = w_alu_a + w_alu_b;
        3'b001:  w_alu_result = w_alu_a - w_alu_b;
        3'b010:  w_alu_result = w_alu_a & w_alu_b;
        3'b011:  w_alu_result = w_alu_a | w_alu_b;
        3'b100:  w_alu_result = w_alu_a ^ w_alu_b;
        3'b101:  w_alu_result = {15'd0, ($signed(w_alu_a) < $signed(w_alu_b))};
        3'b110:  w_alu_result = w_alu_a << w_alu_b[3:0];
        3'b111:  w_alu_result = w_alu_a >> w_alu_b[3:0];
        default: w_alu_result = 16'd0;
      endcase
    end
  end

  assign w_zero = (w_alu_result == 16'd0);

  // Memory read data and write-back mux; outputs forced to 0 during reset.
  always_comb begin
    w_mem_rdata = 16'd0;
    w_wb_data   = 16'd0;
    if (bus.memread) begin
      w_mem_rdata = r_mem[w_alu_result[7:0]];
    end else begin
      w_mem_rdata = 16'd0;
    end
    if (bus.memtoreg) begin
      w_wb_data = w_mem_rdata;
    end else begin
      w_wb_data = w_alu_result;
    end
  end

  assign bus.out    = reset ? w_wb_data : 16'd0;
  assign bus.pc_out = reset ? r_pc : 16'd0;

  // PC update: jump beats a taken branch, otherwise fall through.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc <= 16'd0;
    end else if (bus.jump) begin
      r_pc <= {w_pc_plus1[15:12], w_tgt};
    end else if (bus.branch && w_zero) begin
      r_pc <= w_pc_plus1 + w_imm_sext;
    end else begin
      r_pc <= w_pc_plus1;
    end
  end

  // Register file write-back; writes to r0 are dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
`ifdef REGFILE_PRELOAD_EN
        r_regs[i] <= 16'(i);
`else
        r_regs[i] <= 16'd0;
`endif
      end
    end else if (bus.regwrite && (w_wr_addr != 3'd0)) begin
      r_regs[w_wr_addr] <= w_wb_data;
    end else begin
      r_regs[0] <= 16'd0;
    end
  end

  // Data memory store of reg[rt] at the ALU-computed address.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int j = 0; j < DMEM_DEPTH; j++) begin
        r_mem[j] <= 16'd0;
      end
    end else if (bus.memwrite) begin
      r_mem[w_alu_result[7:0]] <= w_rt_data;
    end else begin
      r_mem[w_alu_result[7:0]] <= r_mem[w_alu_result[7:0]];
    end
  end
endmodule

// File: tb/tb_data_path_core.sv
// Directed bench for data_path_core: each step queues its expected out/PC
// and compares them against the DUT once the step's inputs settle.
module tb_data_path_core;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  data_path_core_if bus();
  data_path_core dut (.clk(clk), .reset(reset), .bus(bus));

`ifdef REGFILE_PRELOAD_EN
  localparam bit PRE = 1'b1;
`else
  localparam bit PRE = 1'b0;
`endif

  // ctrl = {regdest, alusrc, memtoreg, regwrite, memread, memwrite, branch, jump}
  localparam logic [7:0] C_NOP   = 8'b0000_0000;
  localparam logic [7:0] C_RTYPE = 8'b1001_0000;
  localparam logic [7:0] C_ADDI  = 8'b0101_0000;
  localparam logic [7:0] C_SW    = 8'b0100_0100;
  localparam logic [7:0] C_LW    = 8'b0111_1000;
  localparam logic [7:0] C_LDNW  = 8'b0110_1000;
  localparam logic [7:0] C_NORD  = 8'b0110_0000;
  localparam logic [7:0] C_SWRD  = 8'b0110_1100;
  localparam logic [7:0] C_BEQ   = 8'b0000_0010;
  localparam logic [7:0] C_J     = 8'b0100_0001;
  localparam logic [7:0] C_JB    = 8'b0000_0011;

  typedef struct packed {
    logic [2:0]  f;
    logic [2:0]  rs;
    logic [2:0]  rt;
    logic [15:0] exp;
  } alu_vec_t;

  // r1 = 7, r2 = 0xFFFD when this table runs.
  alu_vec_t alu_tab [10] = '{
    '{3'd0, 3'd1, 3'd2, 16'h0004},
    '{3'd1, 3'd1, 3'd2, 16'h000A},
    '{3'd2, 3'd1, 3'd2, 16'h0005},
    '{3'd3, 3'd1, 3'd2, 16'hFFFF},
    '{3'd4, 3'd1, 3'd2, 16'hFFFA},
    '{3'd5, 3'd1, 3'd2, 16'h0000},
    '{3'd5, 3'd2, 3'd1, 16'h0001},
    '{3'd6, 3'd1, 3'd2, 16'hE000},
    '{3'd7, 3'd2, 3'd1, 16'h01FF},
    '{3'd1, 3'd2, 3'd1, 16'hFFF6}
  };

  int errors = 0;
  int checks = 0;
  logic [15:0] exp_q [$];
  logic [15:0] pc_q  [$];
  logic [15:0] m_pc;
  logic [15:0] m_nxt;
  logic [15:0] instr;

  function automatic logic [15:0] enc_r(input logic [3:0] op, input logic [2:0] rs,
                                        input logic [2:0] rt, input logic [2:0] rd,
                                        input logic [2:0] f);
    return {op, rs, rt, rd, f};
  endfunction

  function automatic logic [15:0] enc_i(input logic [3:0] op, input logic [2:0] rs,
                                        input logic [2:0] rt, input logic [5:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic drive(input logic [15:0] ins, input logic [7:0] ctrl);
    {bus.regdest, bus.alusrc, bus.memtoreg, bus.regwrite,
     bus.memread, bus.memwrite, bus.branch, bus.jump} = ctrl;
    bus.instruct_reg = ins;
  endtask

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Entered at posedge+1; leaves at the next posedge+1.
  task automatic exec(input string tag, input logic [15:0] ins, input logic [7:0] ctrl,
                      input logic [15:0] exp_out, input logic [15:0] exp_next);
    drive(ins, ctrl);
    exp_q.push_back(exp_out);
    pc_q.push_back(m_pc);
    #2;
    chk({tag, "_pc"}, bus.pc_out, pc_q.pop_front());
    chk({tag, "_out"}, bus.out, exp_q.pop_front());
    m_pc = exp_next;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    m_pc  = 16'd0;
    // Inputs active during reset must neither show on out nor write state.
    drive(enc_i(4'd1, 3'd0, 3'd1, 6'd5), C_ADDI);
    #3;
    chk("rst_out", bus.out, 16'd0);
    chk("rst_pc", bus.pc_out, 16'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_hold_out", bus.out, 16'd0);
    drive(16'd0, C_NOP);
    reset = 1'b1;
    m_pc  = 16'd0;

    exec("pre_add", 16'h0880, C_RTYPE, PRE ? 16'd6 : 16'd0, m_pc + 16'd1);
    exec("rst_nowrite", enc_r(4'd0, 3'd1, 3'd0, 3'd0, 3'd0), C_NOP,
         PRE ? 16'd1 : 16'd0, m_pc + 16'd1);
    exec("r0_zero", enc_r(4'd0, 3'd0, 3'd0, 3'd5, 3'd0), C_NOP, 16'd0, m_pc + 16'd1);
    exec("addi_r1", enc_i(4'd1, 3'd0, 3'd1, 6'd7), C_ADDI, 16'h0007, m_pc + 16'd1);
    exec("addi_r2", enc_i(4'd1, 3'd0, 3'd2, 6'h3D), C_ADDI, 16'hFFFD, m_pc + 16'd1);

    for (int i = 0; i < 10; i++) begin
      exec($sformatf("alu%0d", i), enc_r(4'd0, alu_tab[i].rs, alu_tab[i].rt, 3'd4, alu_tab[i].f),
           C_RTYPE, alu_tab[i].exp, m_pc + 16'd1);
    end
    exec("r4_last", enc_r(4'd0, 3'd4, 3'd0, 3'd0, 3'd0), C_NOP, 16'hFFF6, m_pc + 16'd1);

    exec("raw_a", enc_r(4'd0, 3'd1, 3'd1, 3'd3, 3'd0), C_RTYPE, 16'd14, m_pc + 16'd1);
    exec("raw_b", enc_r(4'd0, 3'd3, 3'd1, 3'd3, 3'd0), C_RTYPE, 16'd21, m_pc + 16'd1);
    exec("raw_c", enc_r(4'd0, 3'd3, 3'd0, 3'd5, 3'd0), C_RTYPE, 16'd21, m_pc + 16'd1);

    exec("sw", enc_i(4'd2, 3'd1, 3'd2, 6'd3), C_SW, 16'h000A, m_pc + 16'd1);
    exec("lw", enc_i(4'd3, 3'd1, 3'd6, 6'd3), C_LW, 16'hFFFD, m_pc + 16'd1);
    exec("lw_r6", enc_r(4'd0, 3'd6, 3'd0, 3'd0, 3'd0), C_NOP, 16'hFFFD, m_pc + 16'd1);
    exec("no_rd", enc_i(4'd3, 3'd1, 3'd6, 6'd3), C_NORD, 16'd0, m_pc + 16'd1);
    exec("sw_rd_old", enc_i(4'd2, 3'd1, 3'd1, 6'd3), C_SWRD, 16'hFFFD, m_pc + 16'd1);
    exec("lw_new", enc_i(4'd3, 3'd1, 3'd6, 6'd3), C_LW, 16'h0007, m_pc + 16'd1);
    exec("lw_clear", enc_i(4'd3, 3'd0, 3'd6, 6'd20), C_LW, 16'd0, m_pc + 16'd1);

    exec("beq_take", enc_i(4'd4, 3'd1, 3'd1, 6'h3E), C_BEQ, 16'd0, m_pc - 16'd1);
    exec("beq_not", enc_i(4'd4, 3'd1, 3'd2, 6'h3E), C_BEQ, 16'h000A, m_pc + 16'd1);
    m_nxt = m_pc + 16'd1;
    exec("jump", 16'h5123, C_J, 16'hFFE3, {m_nxt[15:12], 12'h123});
    instr = enc_i(4'd6, 3'd1, 3'd1, 6'd2);
    m_nxt = m_pc + 16'd1;
    exec("jmp_vs_beq", instr, C_JB, 16'd0, {m_nxt[15:12], instr[11:0]});
    exec("after_jb", enc_r(4'd0, 3'd0, 3'd0, 3'd0, 3'd0), C_NOP, 16'd0, m_pc + 16'd1);

    // Mid-run reset: outputs clear asynchronously, state returns to reset value.
    drive(enc_i(4'd1, 3'd0, 3'd1, 6'd9), C_ADDI);
    reset = 1'b0;
    #1;
    chk("mid_rst_out", bus.out, 16'd0);
    chk("mid_rst_pc", bus.pc_out, 16'd0);
    @(posedge clk);
    #1;
    drive(16'd0, C_NOP);
    reset = 1'b1;
    m_pc  = 16'd0;
    exec("mid_r1", enc_r(4'd0, 3'd1, 3'd0, 3'd0, 3'd0), C_NOP, PRE ? 16'd1 : 16'd0, m_pc + 16'd1);
    exec("mid_r3", enc_r(4'd0, 3'd3, 3'd0, 3'd0, 3'd0), C_NOP, PRE ? 16'd3 : 16'd0, m_pc + 16'd1);
    exec("mid_mem", enc_i(4'd3, 3'd0, 3'd6, 6'd10), C_LDNW, 16'd0, m_pc + 16'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
